// File: rtl/bp_cache_dma_pkg.sv
// Shared types for the cache DMA to memory adapter.
// State enum plus packet declare/width macros.
`ifndef BP_CACHE_DMA_PKG_SV
`define BP_CACHE_DMA_PKG_SV

`define DECLARE_BP_CACHE_DMA_PKT_S(addr_w) \
  typedef struct packed {                  \
    logic              write_not_read;     \
    logic [addr_w-1:0] addr;               \
  } bp_cache_dma_pkt_s

`define BP_CACHE_DMA_PKT_WIDTH(addr_w) (1+(addr_w))

package bp_cache_dma_pkg;

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_read  = 2'd1,
    e_write = 2'd2
  } bp_cache_dma_state_e;

endpackage

`endif

// File: rtl/bp_cache_dma_beat_ctr.sv
// Clear/up/down beat counter with terminal-count flag.
// Ports: clk_i, reset_i, clear_i, up_i, down_i -> count_o, tc_o (count == term_p).
module bp_cache_dma_beat_ctr
  import bp_cache_dma_pkg::*;
#(
  parameter int width_p = 4,
  parameter int term_p  = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o,
  output logic               tc_o
);

  logic [width_p-1:0] count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i)
      count_r <= '0;
    else if (up_i & ~down_i)
      count_r <= count_r + 1'b1;
    else if (down_i & ~up_i)
      count_r <= count_r - 1'b1;
  end

  assign count_o = count_r;
  assign tc_o    = (count_r == width_p'(term_p));

endmodule

// File: rtl/bp_cache_dma_to_mem.sv
// Cache DMA port to per-beat memory command adapter, one block at a time.
// Ports: dma_pkt_* (block request), dma_data_* (fill out / evict in),
//   mem_cmd_* (addr/we/data valid/ready), mem_resp_* (in-order read data),
//   perf_*_blocks_o (counters when BP_CACHE_DMA_PERF_EN is defined, else 0).
module bp_cache_dma_to_mem
  import bp_cache_dma_pkg::*;
#(
  parameter int caddr_width_p        = 32,
  parameter int fill_width_p         = 64,
  parameter int block_size_in_fill_p = 8,
  parameter int max_outstanding_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic [`BP_CACHE_DMA_PKT_WIDTH(caddr_width_p)-1:0] dma_pkt_i,
  input  logic                     dma_pkt_v_i,
  output logic                     dma_pkt_yumi_o,

  output logic [fill_width_p-1:0]  dma_data_o,
  output logic                     dma_data_v_o,
  input  logic                     dma_data_ready_and_i,

  input  logic [fill_width_p-1:0]  dma_data_i,
  input  logic                     dma_data_v_i,
  output logic                     dma_data_yumi_o,

  output logic [caddr_width_p-1:0] mem_cmd_addr_o,
  output logic                     mem_cmd_we_o,
  output logic [fill_width_p-1:0]  mem_cmd_data_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_and_i,

  input  logic [fill_width_p-1:0]  mem_resp_data_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_ready_and_o,

  output logic [31:0]              perf_read_blocks_o,
  output logic [31:0]              perf_write_blocks_o
);

  localparam int lg_n_lp  = $clog2(block_size_in_fill_p);
  localparam int cnt_w_lp = lg_n_lp + 1;
  localparam int lg_s_lp  = $clog2(fill_width_p/8);
  localparam int lg_b_lp  = lg_s_lp + lg_n_lp;

  localparam logic [caddr_width_p-1:0] blk_mask_lp =
    caddr_width_p'((64'd1 << lg_b_lp) - 64'd1);

  `DECLARE_BP_CACHE_DMA_PKT_S(caddr_width_p);

  bp_cache_dma_pkt_s pkt;
  assign pkt = dma_pkt_i;

  bp_cache_dma_state_e state_r, state_n;
  logic [caddr_width_p-1:0] base_r;

  logic [cnt_w_lp-1:0] cmd_cnt, resp_cnt, cred_cnt;
  logic cmd_tc, resp_tc, cred_tc;
  logic clear, cmd_up, resp_up, cred_up, cred_down;

  logic [caddr_width_p-1:0] cmd_addr;
  logic cmd_last;

  // Base keeps all pkt bits; alignment is applied on use.
  assign cmd_addr = (base_r & ~blk_mask_lp)
                  + (caddr_width_p'(cmd_cnt) << lg_s_lp);

  assign cmd_last =
    (cmd_cnt == cnt_w_lp'(block_size_in_fill_p-1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_ready;
      base_r  <= '0;
    end else begin
      state_r <= state_n;
      if (clear)
        base_r <= pkt.addr;
    end
  end

  // Outputs stay 0 during reset regardless of state.
  always_comb begin
    state_n              = state_r;
    dma_pkt_yumi_o       = 1'b0;
    dma_data_o           = '0;
    dma_data_v_o         = 1'b0;
    dma_data_yumi_o      = 1'b0;
    mem_cmd_addr_o       = '0;
    mem_cmd_we_o         = 1'b0;
    mem_cmd_data_o       = '0;
    mem_cmd_v_o          = 1'b0;
    mem_resp_ready_and_o = 1'b0;
    clear                = 1'b0;
    cmd_up               = 1'b0;
    resp_up              = 1'b0;
    cred_up              = 1'b0;
    cred_down            = 1'b0;
    if (!reset_i) begin
      unique case (state_r)
        e_ready: begin
          dma_pkt_yumi_o = dma_pkt_v_i;
          if (dma_pkt_v_i) begin
            clear   = 1'b1;
            state_n = pkt.write_not_read
                    ? e_write : e_read;
          end
        end
        e_read: begin
          mem_cmd_v_o    = ~cmd_tc & ~cred_tc;
          mem_cmd_addr_o = cmd_addr;
          dma_data_o     = mem_resp_data_i;
          dma_data_v_o   = mem_resp_v_i;
          mem_resp_ready_and_o = dma_data_ready_and_i;
          cmd_up    = mem_cmd_v_o & mem_cmd_ready_and_i;
          resp_up   = mem_resp_v_i & dma_data_ready_and_i;
          cred_up   = cmd_up;
          cred_down = resp_up;
          if (resp_up & resp_tc)
            state_n = e_ready;
        end
        e_write: begin
          mem_cmd_v_o     = dma_data_v_i;
          mem_cmd_we_o    = 1'b1;
          mem_cmd_addr_o  = cmd_addr;
          mem_cmd_data_o  = dma_data_i;
          dma_data_yumi_o = dma_data_v_i
                          & mem_cmd_ready_and_i;
          cmd_up = dma_data_yumi_o;
          if (dma_data_yumi_o & cmd_last)
            state_n = e_ready;
        end
        default: state_n = e_ready;
      endcase
    end
  end

  bp_cache_dma_beat_ctr #(
    .width_p(cnt_w_lp),
    .term_p (block_size_in_fill_p)
  ) u_cmd_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .up_i   (cmd_up),
    .down_i (1'b0),
    .count_o(cmd_cnt),
    .tc_o   (cmd_tc)
  );

  bp_cache_dma_beat_ctr #(
    .width_p(cnt_w_lp),
    .term_p (block_size_in_fill_p-1)
  ) u_resp_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .up_i   (resp_up),
    .down_i (1'b0),
    .count_o(resp_cnt),
    .tc_o   (resp_tc)
  );

  bp_cache_dma_beat_ctr #(
    .width_p(cnt_w_lp),
    .term_p (max_outstanding_p)
  ) u_credits (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clear_i(clear),
    .up_i   (cred_up),
    .down_i (cred_down),
    .count_o(cred_cnt),
    .tc_o   (cred_tc)
  );

  logic unused_cnt;
  assign unused_cnt = ^{resp_cnt, cred_cnt};

`ifdef BP_CACHE_DMA_PERF_EN
  logic [31:0] perf_rd_r, perf_wr_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_rd_r <= '0;
      perf_wr_r <= '0;
    end else begin
      if (state_r == e_read && state_n == e_ready)
        perf_rd_r <= perf_rd_r + 32'd1;
      if (state_r == e_write && state_n == e_ready)
        perf_wr_r <= perf_wr_r + 32'd1;
    end
  end

  assign perf_read_blocks_o  = perf_rd_r;
  assign perf_write_blocks_o = perf_wr_r;
`else
  assign perf_read_blocks_o  = '0;
  assign perf_write_blocks_o = '0;
`endif

  // Memory must only answer reads of the block in flight.
  a_no_stray_resp: assert property (
    @(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> (state_r == e_read)
  );

endmodule
